// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a single
// full-subtractor cell and a borrow flip-flop behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_cat;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             x, y, d, br_next, last_bit;

    // res_sh keeps only the WIDTH-1 bits already produced; the current bit
    // completes the word in res_cat, so no result bit is ever discarded.
    always_comb begin
        x        = a_sh[0];
        y        = b_sh[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        res_cat  = {d, res_sh};
        last_bit = (cnt == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SHIFT);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_cat[WIDTH-1:1];
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    // On the last bit x and y are the operand sign bits.
                    if (last_bit) begin
                        diff   <= res_cat;
                        borrow <= br_next;
                        ovf    <= (x ^ y) & (d ^ x);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=2 instances checked every cycle
// against a cycle-count/arithmetic model, plus hand-computed directed results.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, busy8, done8, borrow8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start2, busy2, done2, borrow2, ovf2;
    logic [1:0] a2, b2, diff2;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .ovf(ovf2)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase counts cycles since the accepting edge (0 = idle).
    int          phase [2];
    logic [31:0] pend_d [2];
    logic        pend_b [2];
    logic        pend_o [2];
    logic [31:0] m_diff [2];
    logic        m_borrow [2];
    logic        m_ovf [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; m_diff[k] = '0; m_borrow[k] = 1'b0; m_ovf[k] = 1'b0;
            pend_d[k] = '0; pend_b[k] = 1'b0; pend_o[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic        st;
            logic [31:0] av, bv, mask, dd;
            w  = (k == 0) ? 8 : 2;
            st = (k == 0) ? start8 : start2;
            av = (k == 0) ? 32'(a8) : 32'(a2);
            bv = (k == 0) ? 32'(b8) : 32'(b2);
            if (rst) begin
                phase[k] = 0; m_diff[k] = '0; m_borrow[k] = 1'b0; m_ovf[k] = 1'b0;
            end else if (phase[k] == 0) begin
                if (st) begin
                    mask      = (32'd1 << w) - 32'd1;
                    dd        = (av - bv) & mask;
                    pend_d[k] = dd;
                    pend_b[k] = (av < bv);
                    pend_o[k] = (av[w-1] != bv[w-1]) && (dd[w-1] != av[w-1]);
                    phase[k]  = 1;
                end
            end else if (phase[k] < w) begin
                phase[k] = phase[k] + 1;
            end else if (phase[k] == w) begin
                phase[k]    = w + 1;
                m_diff[k]   = pend_d[k];
                m_borrow[k] = pend_b[k];
                m_ovf[k]    = pend_o[k];
            end else begin
                phase[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8",   32'(busy8),   32'(phase[0] >= 1 && phase[0] <= 8));
            check("done8",   32'(done8),   32'(phase[0] == 9));
            check("diff8",   32'(diff8),   m_diff[0]);
            check("borrow8", 32'(borrow8), 32'(m_borrow[0]));
            check("ovf8",    32'(ovf8),    32'(m_ovf[0]));
            check("busy2",   32'(busy2),   32'(phase[1] >= 1 && phase[1] <= 2));
            check("done2",   32'(done2),   32'(phase[1] == 3));
            check("diff2",   32'(diff2),   m_diff[1]);
            check("borrow2", 32'(borrow2), 32'(m_borrow[1]));
            check("ovf2",    32'(ovf2),    32'(m_ovf[1]));
        end
    end

    task automatic run(input int k, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] d, output logic br, output logic ov,
                       output int nbusy);
        bit got;
        @(posedge clk); #2;
        if (k == 0) begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; end
        else        begin start2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; end
        @(posedge clk); #2;
        start8 = 1'b0; start2 = 1'b0;
        nbusy = 0; got = 1'b0; d = '0; br = 1'b0; ov = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((k == 0) ? busy8 : busy2) nbusy++;
            if ((k == 0) ? done8 : done2) begin
                got = 1'b1;
                d   = (k == 0) ? 32'(diff8) : 32'(diff2);
                br  = (k == 0) ? borrow8 : borrow2;
                ov  = (k == 0) ? ovf8 : ovf2;
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    logic [31:0] rd;
    logic        rb, ro;
    int          nb, ndone;
    int          done_cyc [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow_ovf", 32'({borrow8, ovf8}), 32'd0);

        run(0, 32'h35, 32'h12, rd, rb, ro, nb);
        check("x35m12_diff", rd, 32'h23);
        check("x35m12_flags", 32'({rb, ro}), 32'b00);
        check("x35m12_busy_cycles", 32'(nb), 32'd8);

        run(0, 32'h12, 32'h35, rd, rb, ro, nb);
        check("x12m35_diff", rd, 32'hDD);
        check("x12m35_flags", 32'({rb, ro}), 32'b10);

        run(0, 32'h80, 32'h01, rd, rb, ro, nb);
        check("x80m01_diff", rd, 32'h7F);
        check("x80m01_flags", 32'({rb, ro}), 32'b01);

        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                run(1, 32'(ai), 32'(bi), rd, rb, ro, nb);
                check("w2_diff", rd, 32'((ai - bi) & 3));
                check("w2_borrow", 32'(rb), 32'(ai < bi));
                check("w2_busy_cycles", 32'(nb), 32'd2);
            end
        end

        // Re-pulse start during SHIFT with new operands; also change operands after capture.
        @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h0F;
        @(posedge clk); #2;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        repeat (2) @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #2;
        start8 = 1'b0;
        ndone = 0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin ndone++; rd = 32'(diff8); end
        end
        check("repulse_done_count", 32'(ndone), 32'd1);
        check("repulse_diff", rd, 32'h46);

        // Reset three edges into SHIFT aborts the operation.
        @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (3) @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow_ovf", 32'({borrow8, ovf8}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run(0, 32'h10, 32'h01, rd, rb, ro, nb);
        check("x10m01_diff", rd, 32'h0F);

        // Start held high: one operation per WIDTH+2 cycles.
        @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        for (int i = 0; i < 60 && done_cyc.size() < 4; i++) begin
            @(negedge clk);
            if (done8) begin
                done_cyc.push_back(cyc);
                check("held_diff", 32'(diff8), 32'h00);
                check("held_borrow", 32'(borrow8), 32'd0);
            end
        end
        @(posedge clk); #2;
        start8 = 1'b0;
        check("held_done_count", 32'(done_cyc.size()), 32'd4);
        for (int i = 1; i < done_cyc.size(); i++)
            check("held_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'd10);
        repeat (12) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart to the team's ripple-carry full-adder blocks. It trades area for latency: one difference bit per cycle instead of a WIDTH-deep borrow chain. It sits behind a simple start/done handshake so a controller or testbench can issue operations back to back.

## Interface

- `WIDTH`, default 8: operand and result width in bits; legal range 2 to 32.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new operation; sampled only in IDLE.
- `a`  in  WIDTH: minuend; captured on the edge that accepts `start`.
- `b`  in  WIDTH: subtrahend; captured on the edge that accepts `start`.
- `busy`  out  1: high while bits are being processed (SHIFT state).
- `done`  out  1: one-cycle pulse; `diff`, `borrow` and `ovf` are valid from this cycle onward.
- `diff`  out  WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow`  out  1: final borrow; 1 iff `a < b` unsigned.
- `ovf`  out  1: signed overflow; `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`.

## Operation

- States: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start == 1`: load `a` and `b` into internal shift registers, clear the borrow flip-flop and the bit counter, then go to SHIFT.
  - Otherwise remain in IDLE.
- **SHIFT**, once per edge:
  - Take the LSB of each operand: `x = a_sh[0]`, `y = b_sh[0]`, `br` = borrow flip-flop.
  - Difference bit: `d = x ^ y ^ br`.
  - Next borrow: `br' = (~x & y) | (~(x ^ y) & br)`.
  - Shift both operand registers right by one.
  - Shift `d` into the MSB of the internal result register.
  - Increment the counter.
  - When the counter reaches WIDTH-1 (i.e. processing the last bit), go to DONE on the same edge.
  - On that same edge, copy the completed result into `diff`, `br'` into `borrow`, and the computed overflow into `ovf`.
- **DONE**: `done = 1` for this single cycle; return to IDLE on the next edge unconditionally.
- `start` is ignored in SHIFT and DONE; it is not queued.
- Operand changes on `a` and `b` after capture have no effect on the operation in progress.
- `diff`, `borrow` and `ovf` hold their values until the completion edge of the next operation; they are never partially updated.
- The counter width is `$clog2(WIDTH)` bits, sized so that WIDTH-1 is representable.

## Timing

- Reset: state = IDLE, and `busy`, `done`, `diff`, `borrow`, `ovf`, the internal registers and the counter are all 0.
- Reset has priority over every other event, including `start` on the same edge and a reset arriving in the middle of SHIFT.
- A reset during an operation aborts it; no `done` pulse is produced.
- Latency, with edge E0 accepting `start`:
  - Edges E1..E_WIDTH process bits 0..WIDTH-1.
  - `done` is high in the cycle between E_WIDTH and E_WIDTH+1.
- `busy` is high from the cycle after E0 through E_WIDTH; it is low in the DONE cycle.
- Throughput: the earliest next accepted `start` is at E_WIDTH+2 (start held continuously), giving one operation per WIDTH+2 cycles.
- `done` and `busy` are never high at the same time.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- WIDTH=8, `a=0x35`, `b=0x12`, pulse `start` -> `busy` high for 8 cycles, then `done` pulse with `diff=0x23`, `borrow=0`, `ovf=0`.
- WIDTH=8, `a=0x12`, `b=0x35` -> `diff=0xDD`, `borrow=1`, `ovf=0`; a second case `a=0x80`, `b=0x01` -> `diff=0x7F`, `borrow=0`, `ovf=1`.
- WIDTH=2, all 16 `{a,b}` combinations sequentially -> each result equals `(a-b)&3`, and `borrow=(a<b)`.
- WIDTH=8, `a=0x55`, `b=0x0F` started, then `start` re-pulsed with `a=0xFF`, `b=0xFF` during SHIFT -> the second request is ignored; `diff=0x46` and exactly one `done`.
- WIDTH=8, `rst` asserted 3 cycles into SHIFT -> the next cycle has all outputs 0 and state IDLE, no `done` pulse follows; a subsequent `0x10-0x01` yields `0x0F`.
- WIDTH=8, `start` held high continuously with `a=0x00`, `b=0x00` -> `done` pulses every 10 cycles, `diff=0x00`, `borrow=0`.
